// File: rtl/axi_sram_slave_if.sv
// AXI3 read/write channel bundle between a bus master and axi_sram_slave.
// lock/cache/prot are deliberately absent: the slave ignores them.
interface axi_sram_slave_if #(
   parameter int ID_W   = 4,
   parameter int ADDR_W = 32
) ();

   // Read address channel
   logic [ID_W-1:0]   arid;
   logic [ADDR_W-1:0] araddr;
   logic [7:0]        arlen;
   logic [2:0]        arsize;
   logic [1:0]        arburst;
   logic              arvalid;
   logic              arready;

   // Read data channel
   logic [ID_W-1:0]   rid;
   logic [31:0]       rdata;
   logic [1:0]        rresp;
   logic              rlast;
   logic              rvalid;
   logic              rready;

   // Write address channel
   logic [ID_W-1:0]   awid;
   logic [ADDR_W-1:0] awaddr;
   logic [7:0]        awlen;
   logic [2:0]        awsize;
   logic [1:0]        awburst;
   logic              awvalid;
   logic              awready;

   // Write data channel
   logic [ID_W-1:0]   wid;
   logic [31:0]       wdata;
   logic [3:0]        wstrb;
   logic              wlast;
   logic              wvalid;
   logic              wready;

   // Write response channel
   logic [ID_W-1:0]   bid;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready,
      output awid, awaddr, awlen, awsize, awburst, awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready,
      input  awid, awaddr, awlen, awsize, awburst, awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready
   );

endinterface

// File: rtl/axi_sram_slave.sv
// AXI3 slave that turns read/write bursts into single-port synchronous SRAM
// accesses. One transaction in flight at a time; a read wins a same-cycle
// tie against a write. The SRAM has one cycle of read latency.
module axi_sram_slave #(
   parameter int ID_W    = 4,
   parameter int ADDR_W  = 32,
   parameter int SRAM_AW = 16
) (
   input  logic               aclk,
   input  logic               aresetn,
   axi_sram_slave_if.slave    axi,
   output logic               sram_en,
   output logic [3:0]         sram_we,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [31:0]        sram_wdata,
   input  logic [31:0]        sram_rdata
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] RD_REQ  = 3'd1;
   localparam logic [2:0] RD_WAIT = 3'd2;
   localparam logic [2:0] RD_RESP = 3'd3;
   localparam logic [2:0] WR_DATA = 3'd4;
   localparam logic [2:0] WR_RESP = 3'd5;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic [2:0]        state;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        len;
   logic [2:0]        size;
   logic [1:0]        burst;
   // One bit wider than len and saturating, so a long wlast overrun can never
   // wrap back into the legal range and re-enable SRAM writes.
   logic [8:0]        cnt;
   logic              req_err;

   logic [ID_W-1:0]   rid_q;
   logic [ID_W-1:0]   bid_q;
   logic [31:0]       rdata_q;
   logic [1:0]        rresp_q;
   logic [1:0]        bresp_q;

   logic ar_fire;
   logic aw_fire;
   logic r_fire;
   logic w_fire;
   logic b_fire;
   logic beat_is_last;
   logic wr_in_range;

   // wid is accepted but intentionally not compared against the latched awid.
   logic unused_wid;
   assign unused_wid = ^axi.wid;

   // WRAP is executed as INCR and sizes wider than the 32-bit data bus are
   // not supported; both are reported as SLVERR rather than rejected.
   function automatic logic req_error(input logic [2:0] sz, input logic [1:0] bt);
      return (bt == BURST_WRAP) || (sz > 3'd2);
   endfunction

   // FIXED holds the address; INCR, WRAP and reserved encodings step by the
   // transfer size and wrap modulo 2^ADDR_W.
   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                   input logic [2:0]        sz,
                                                   input logic [1:0]        bt);
      logic [ADDR_W-1:0] n;
      if (bt == BURST_FIXED) n = a;
      else                   n = a + (ADDR_W'(1) << sz);
      return n;
   endfunction

   // Handshake ready/valid outputs; gating with aresetn keeps them low during
   // the reset cycle even if the state register has not yet returned to IDLE.
   assign axi.arready = aresetn & (state == IDLE);
   assign axi.awready = aresetn & (state == IDLE) & ~axi.arvalid;
   assign axi.wready  = aresetn & (state == WR_DATA);
   assign axi.rvalid  = aresetn & (state == RD_RESP);
   assign axi.bvalid  = aresetn & (state == WR_RESP);

   assign axi.rid   = rid_q;
   assign axi.rdata = rdata_q;
   assign axi.rresp = rresp_q;
   assign axi.bid   = bid_q;
   assign axi.bresp = bresp_q;

   assign beat_is_last = (cnt == {1'b0, len});
   assign wr_in_range  = (cnt <= {1'b0, len});
   assign axi.rlast    = (state == RD_RESP) & beat_is_last;

   assign ar_fire = axi.arvalid & axi.arready;
   assign aw_fire = axi.awvalid & axi.awready;
   assign r_fire  = axi.rvalid  & axi.rready;
   assign w_fire  = axi.wvalid  & axi.wready;
   assign b_fire  = axi.bvalid  & axi.bready;

   // SRAM port: a read strobe in RD_REQ, or a same-cycle write for each
   // in-range W beat; overrun beats are accepted without touching the SRAM.
   always_comb begin
      // NOTE: every output gets a default first so no path through the case
      // leaves a value held, which would otherwise infer a latch.
      sram_en    = 1'b0;
      sram_we    = 4'b0000;
      sram_addr  = addr[SRAM_AW+1:2];
      sram_wdata = axi.wdata;
      case (state)
         RD_REQ: begin
            sram_en = 1'b1;
         end
         WR_DATA: begin
            if (w_fire && wr_in_range) begin
               sram_en = 1'b1;
               sram_we = axi.wstrb;
            end
         end
         default: ;
      endcase
   end

   // Transaction FSM plus the latched request and response registers.
   always_ff @(posedge aclk) begin
      // NOTE: non-blocking assignments throughout, so every register here
      // sees the pre-edge value of every other one regardless of order.
      if (!aresetn) begin
         state   <= IDLE;
         addr    <= '0;
         len     <= '0;
         size    <= '0;
         burst   <= '0;
         cnt     <= '0;
         req_err <= 1'b0;
         rid_q   <= '0;
         bid_q   <= '0;
         rdata_q <= '0;
         rresp_q <= RESP_OKAY;
         bresp_q <= RESP_OKAY;
      end else begin
         case (state)
            IDLE: begin
               if (ar_fire) begin
                  addr    <= axi.araddr;
                  len     <= axi.arlen;
                  size    <= axi.arsize;
                  burst   <= axi.arburst;
                  cnt     <= '0;
                  req_err <= req_error(axi.arsize, axi.arburst);
                  rid_q   <= axi.arid;
                  rresp_q <= req_error(axi.arsize, axi.arburst) ? RESP_SLVERR : RESP_OKAY;
                  state   <= RD_REQ;
               end else if (aw_fire) begin
                  addr    <= axi.awaddr;
                  len     <= axi.awlen;
                  size    <= axi.awsize;
                  burst   <= axi.awburst;
                  cnt     <= '0;
                  req_err <= req_error(axi.awsize, axi.awburst);
                  bid_q   <= axi.awid;
                  state   <= WR_DATA;
               end
            end

            RD_REQ: begin
               state <= RD_WAIT;
            end

            RD_WAIT: begin
               rdata_q <= sram_rdata;
               state   <= RD_RESP;
            end

            RD_RESP: begin
               if (r_fire) begin
                  if (beat_is_last) begin
                     state <= IDLE;
                  end else begin
                     addr  <= next_addr(addr, size, burst);
                     cnt   <= cnt + 9'd1;
                     state <= RD_REQ;
                  end
               end
            end

            WR_DATA: begin
               if (w_fire) begin
                  addr <= next_addr(addr, size, burst);
                  if (cnt != 9'h1FF) cnt <= cnt + 9'd1;
                  if (axi.wlast) begin
                     // Early or late wlast both show up as cnt != len here.
                     bresp_q <= (req_err || !beat_is_last) ? RESP_SLVERR : RESP_OKAY;
                     state   <= WR_RESP;
                  end
               end
            end

            WR_RESP: begin
               if (b_fire) state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: a behavioural SRAM, a table of
// read bursts, hand-written write / tie / reset sequences, and R/B
// scoreboards that compare every presented response beat.
module tb_axi_sram_slave;

   logic        aclk;
   logic        aresetn;
   logic        sram_en;
   logic [3:0]  sram_we;
   logic [15:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;

   int checks = 0;
   int errors = 0;

   axi_sram_slave_if #(.ID_W(4), .ADDR_W(32)) bus ();

   axi_sram_slave #(.ID_W(4), .ADDR_W(32), .SRAM_AW(16)) dut (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .axi        (bus),
      .sram_en    (sram_en),
      .sram_we    (sram_we),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running, required to finish");
      $fatal(1, "watchdog");
   end

   // ---------------- behavioural SRAM and reference memory ----------------
   logic [31:0] mem [65536];
   bit          written [65536];
   int          wr_count = 0;
   bit   [31:0] ref_map [int];

   function automatic logic [31:0] init_val(input logic [15:0] w);
      if (w == 16'd4) return 32'hDEADBEEF;
      return {w ^ 16'hC3A5, ~w};
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
      return r;
   endfunction

   function automatic logic [31:0] cur_word(input logic [15:0] w);
      return written[w] ? mem[w] : init_val(w);
   endfunction

   function automatic logic [31:0] ref_word(input logic [31:0] a);
      logic [15:0] w;
      w = a[17:2];
      return ref_map.exists(int'(w)) ? ref_map[int'(w)] : init_val(w);
   endfunction

   always @(posedge aclk) begin
      if (sram_en) begin
         if (|sram_we) begin
            mem[sram_addr]     <= merge(cur_word(sram_addr), sram_wdata, sram_we);
            written[sram_addr] <= 1'b1;
            wr_count           <= wr_count + 1;
         end else begin
            sram_rdata <= cur_word(sram_addr);
         end
      end
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: no DUT response within the cycle budget, required one", name);
   endtask

   // ---------------- scoreboards ----------------
   typedef struct {
      logic [3:0]  id;
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } r_exp_t;

   typedef struct {
      logic [3:0] id;
      logic [1:0] resp;
   } b_exp_t;

   r_exp_t sb_r[$];
   b_exp_t sb_b[$];

   // Every presented beat is compared (also while stalled, which checks that
   // it is held stable); it is retired only on the handshake.
   always @(negedge aclk) begin
      if (bus.rvalid) begin
         if (sb_r.size() == 0) check("r_unexpected", bus.rvalid, 1'b0);
         else begin
            check("rid",   bus.rid,   sb_r[0].id);
            check("rdata", bus.rdata, sb_r[0].data);
            check("rresp", bus.rresp, sb_r[0].resp);
            check("rlast", bus.rlast, sb_r[0].last);
            if (bus.rready) void'(sb_r.pop_front());
         end
      end
      if (bus.bvalid) begin
         if (sb_b.size() == 0) check("b_unexpected", bus.bvalid, 1'b0);
         else begin
            check("bid",   bus.bid,   sb_b[0].id);
            check("bresp", bus.bresp, sb_b[0].resp);
            if (bus.bready) void'(sb_b.pop_front());
         end
      end
   end

   // ---------------- read vectors ----------------
   typedef struct {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic [1:0]  exp_resp;
      int          stall_beat;
      int          stall_cycles;
   } rd_vec_t;

   rd_vec_t vecs [8];

   task automatic push_read(input rd_vec_t v);
      logic [31:0] a;
      r_exp_t      e;
      a = v.addr;
      for (int b = 0; b <= int'(v.len); b++) begin
         e.id   = v.id;
         e.data = ref_word(a);
         e.resp = v.exp_resp;
         e.last = (b == int'(v.len));
         sb_r.push_back(e);
         if (v.burst != 2'b00) a = a + (32'd1 << v.size);
      end
   endtask

   task automatic ar_handshake(input rd_vec_t v, output bit ok);
      bus.arid    = v.id;
      bus.araddr  = v.addr;
      bus.arlen   = v.len;
      bus.arsize  = v.size;
      bus.arburst = v.burst;
      bus.arvalid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge aclk);
         if (bus.arready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge aclk);
      #1;
      bus.arvalid = 1'b0;
      if (!ok) timeout_fail("ar_handshake");
   endtask

   task automatic run_read(input rd_vec_t v);
      bit ok;
      int n;
      push_read(v);
      ar_handshake(v, ok);
      if (!ok) begin
         sb_r.delete();
         return;
      end
      for (int b = 0; b <= int'(v.len); b++) begin
         bus.rready = (b == v.stall_beat) ? 1'b0 : 1'b1;
         n  = 0;
         ok = 1'b0;
         for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            n++;
            if (bus.rvalid) begin
               ok = 1'b1;
               break;
            end
         end
         if (!ok) begin
            timeout_fail("r_beat");
            sb_r.delete();
            bus.rready = 1'b1;
            return;
         end
         check("r_latency", n, 3);
         if (b == v.stall_beat) begin
            for (int k = 1; k < v.stall_cycles; k++) begin
               @(posedge aclk);
               #1;
               @(negedge aclk);
            end
            @(posedge aclk);
            #1;
            bus.rready = 1'b1;
            @(negedge aclk);
         end
         @(posedge aclk);
         #1;
      end
      check("r_sb_empty", sb_r.size(), 0);
   endtask

   // ---------------- write sequences ----------------
   logic [31:0] wd [4];
   logic [3:0]  ws [4];

   task automatic run_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                            input logic [1:0] exp_resp, input int bstall, input bit aw_done);
      logic [31:0] a;
      int          wc0;
      int          n_wr;
      bit          ok;
      b_exp_t      be;
      be.id   = id;
      be.resp = exp_resp;
      sb_b.push_back(be);
      wc0 = wr_count;
      if (!aw_done) begin
         bus.awid    = id;
         bus.awaddr  = addr;
         bus.awlen   = len;
         bus.awsize  = size;
         bus.awburst = burst;
         bus.awvalid = 1'b1;
         ok = 1'b0;
         for (int i = 0; i < 50; i++) begin
            @(negedge aclk);
            if (bus.awready) begin
               ok = 1'b1;
               break;
            end
         end
         @(posedge aclk);
         #1;
         bus.awvalid = 1'b0;
         if (!ok) begin
            timeout_fail("aw_handshake");
            sb_b.delete();
            return;
         end
      end
      a = addr;
      for (int b = 0; b < nbeats; b++) begin
         bus.wid    = id;
         bus.wdata  = wd[b];
         bus.wstrb  = ws[b];
         bus.wlast  = (b == nbeats - 1);
         bus.wvalid = 1'b1;
         ok = 1'b0;
         for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (bus.wready) begin
               ok = 1'b1;
               break;
            end
         end
         @(posedge aclk);
         #1;
         if (!ok) begin
            bus.wvalid = 1'b0;
            timeout_fail("w_handshake");
            sb_b.delete();
            return;
         end
         if (b <= int'(len)) begin
            ref_map[int'(a[17:2])] = merge(ref_word(a), wd[b], ws[b]);
            if (burst != 2'b00) a = a + (32'd1 << size);
         end
      end
      bus.wvalid = 1'b0;
      bus.wlast  = 1'b0;
      bus.bready = (bstall == 0);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge aclk);
         if (bus.bvalid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         timeout_fail("b_response");
         sb_b.delete();
         bus.bready = 1'b1;
         return;
      end
      if (bstall != 0) begin
         for (int k = 1; k < bstall; k++) begin
            @(posedge aclk);
            #1;
            @(negedge aclk);
         end
         @(posedge aclk);
         #1;
         bus.bready = 1'b1;
         @(negedge aclk);
      end
      @(posedge aclk);
      #1;
      n_wr = (nbeats < int'(len) + 1) ? nbeats : int'(len) + 1;
      check("sram_write_count", wr_count - wc0, n_wr);
      a = addr;
      for (int b = 0; b < n_wr; b++) begin
         check("sram_word", cur_word(a[17:2]), ref_word(a));
         if (burst != 2'b00) a = a + (32'd1 << size);
      end
      check("b_sb_empty", sb_b.size(), 0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      rd_vec_t     v;
      bit          ok;
      bit          done;
      logic [31:0] iv9;

      //        id     addr           len   size  burst  resp   stall  cycles
      vecs[0] = '{4'd3, 32'h0000_0010, 8'd0, 3'd2, 2'b01, 2'b00, -1, 0};  // single word
      vecs[1] = '{4'd1, 32'h0000_0100, 8'd3, 3'd2, 2'b01, 2'b00,  0, 4};  // stalled 4-beat
      vecs[2] = '{4'd2, 32'h0000_0105, 8'd0, 3'd0, 2'b01, 2'b00, -1, 0};  // narrow read
      vecs[3] = '{4'd7, 32'h0000_0200, 8'd2, 3'd2, 2'b00, 2'b00,  1, 2};  // FIXED
      vecs[4] = '{4'd4, 32'h0000_0110, 8'd1, 3'd2, 2'b10, 2'b10, -1, 0};  // WRAP -> SLVERR
      vecs[5] = '{4'd6, 32'h0000_0120, 8'd1, 3'd3, 2'b01, 2'b10, -1, 0};  // size 3 -> SLVERR
      vecs[6] = '{4'd9, 32'h0004_0010, 8'd0, 3'd2, 2'b01, 2'b00, -1, 0};  // alias of word 4
      vecs[7] = '{4'd5, 32'hFFFF_FFFC, 8'd1, 3'd2, 2'b01, 2'b00, -1, 0};  // 32-bit wrap

      aresetn     = 1'b0;
      bus.arid    = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0;
      bus.arburst = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;
      bus.awid    = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0;
      bus.awburst = '0; bus.awvalid = 1'b0;
      bus.wid     = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
      bus.wvalid  = 1'b0; bus.bready = 1'b1;

      // Reset state
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      check("rst_arready", bus.arready, 1'b0);
      check("rst_awready", bus.awready, 1'b0);
      check("rst_wready",  bus.wready,  1'b0);
      check("rst_rvalid",  bus.rvalid,  1'b0);
      check("rst_bvalid",  bus.bvalid,  1'b0);
      check("rst_sram_en", sram_en,     1'b0);
      check("rst_sram_we", sram_we,     4'h0);
      check("rst_rid",     bus.rid,     4'h0);
      check("rst_bid",     bus.bid,     4'h0);
      check("rst_rdata",   bus.rdata,   32'h0);
      check("rst_rresp",   bus.rresp,   2'b00);
      check("rst_bresp",   bus.bresp,   2'b00);
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
      @(negedge aclk);
      check("idle_arready", bus.arready, 1'b1);
      check("idle_awready", bus.awready, 1'b1);
      @(posedge aclk);
      #1;

      // Table of read bursts
      for (int i = 0; i < 8; i++) run_read(vecs[i]);

      // Two-beat write with partial strobe, B stalled 5 cycles
      wd[0] = 32'h1122_3344; ws[0] = 4'hF;
      wd[1] = 32'hAABB_CCDD; ws[1] = 4'h3;
      run_write(4'd5, 32'h20, 8'd1, 3'd2, 2'b01, 2, 2'b00, 5, 1'b0);
      iv9 = init_val(16'd9);
      check("t3_word8", cur_word(16'd8), 32'h1122_3344);
      check("t3_word9", cur_word(16'd9), {iv9[31:16], 16'hCCDD});
      v = '{4'd8, 32'h20, 8'd1, 3'd2, 2'b01, 2'b00, -1, 0};
      run_read(v);

      // Early wlast (len 3, wlast on beat 2)
      wd[0] = 32'h0BAD_F00D; ws[0] = 4'hF;
      wd[1] = 32'h1357_9BDF; ws[1] = 4'hC;
      run_write(4'd6, 32'h40, 8'd3, 3'd2, 2'b01, 2, 2'b10, 0, 1'b0);

      // Late wlast (len 0, two beats): overrun beat must not reach the SRAM
      wd[0] = 32'hCAFE_0001; ws[0] = 4'hF;
      wd[1] = 32'hCAFE_0002; ws[1] = 4'hF;
      run_write(4'd2, 32'h80, 8'd0, 3'd2, 2'b01, 2, 2'b10, 0, 1'b0);

      // Oversize write is performed but reported as SLVERR
      wd[0] = 32'h7777_8888; ws[0] = 4'hF;
      run_write(4'd1, 32'h90, 8'd0, 3'd3, 2'b01, 1, 2'b10, 0, 1'b0);

      // arvalid and awvalid together: read first, AW held off until R done
      v = '{4'd4, 32'h300, 8'd1, 3'd2, 2'b01, 2'b00, -1, 0};
      push_read(v);
      bus.arid = v.id; bus.araddr = v.addr; bus.arlen = v.len;
      bus.arsize = v.size; bus.arburst = v.burst; bus.arvalid = 1'b1;
      bus.awid = 4'hA; bus.awaddr = 32'h60; bus.awlen = 8'd0;
      bus.awsize = 3'd2; bus.awburst = 2'b01; bus.awvalid = 1'b1;
      bus.rready = 1'b1;
      @(negedge aclk);
      check("tie_arready", bus.arready, 1'b1);
      check("tie_awready", bus.awready, 1'b0);
      @(posedge aclk);
      #1;
      bus.arvalid = 1'b0;
      done = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge aclk);
         check("tie_aw_blocked", bus.awready, 1'b0);
         if (bus.rvalid && bus.rready && bus.rlast) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) timeout_fail("tie_read_done");
      @(posedge aclk);
      #1;
      @(negedge aclk);
      check("tie_aw_after_read", bus.awready, 1'b1);
      @(posedge aclk);
      #1;
      bus.awvalid = 1'b0;
      check("tie_r_sb_empty", sb_r.size(), 0);
      wd[0] = 32'h5566_7788; ws[0] = 4'hF;
      run_write(4'hA, 32'h60, 8'd0, 3'd2, 2'b01, 1, 2'b00, 0, 1'b1);

      // Reset during RD_RESP of a 4-beat burst
      v = '{4'd1, 32'h180, 8'd3, 3'd2, 2'b01, 2'b00, -1, 0};
      bus.rready = 1'b0;
      push_read(v);
      ar_handshake(v, ok);
      done = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge aclk);
         if (bus.rvalid) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) timeout_fail("rst_mid_rvalid");
      @(posedge aclk);
      #1;
      aresetn = 1'b0;
      @(negedge aclk);
      check("mid_rst_rvalid",  bus.rvalid,  1'b0);
      check("mid_rst_arready", bus.arready, 1'b0);
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
      sb_r.delete();
      bus.rready = 1'b1;
      @(negedge aclk);
      check("post_rst_rvalid",  bus.rvalid,  1'b0);
      check("post_rst_arready", bus.arready, 1'b1);
      check("post_rst_rdata",   bus.rdata,   32'h0);
      check("post_rst_rid",     bus.rid,     4'h0);
      @(posedge aclk);
      #1;
      v = '{4'hC, 32'h10, 8'd0, 3'd2, 2'b01, 2'b00, -1, 0};
      run_read(v);

      repeat (3) @(posedge aclk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
